// File: rtl/indicadores_eventos.sv
// Purpose: turns abertura/bandeira event pulses into stretched LED flashes, saturating BCD counters on HEX0..HEX3, and a debug heartbeat on LEDR[9].
// Latency: 1 cycle from event to LEDR[1:0] and to the HEX digits; the first heartbeat toggle lands BLINK_CYCLES cycles after debug rises.
// Backpressure: none; every cycle with an input high is one event and is always accepted.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   abertura          open-cell event pulse  -> LEDR[0], HEX1:HEX0 count
//   bandeira          flag event pulse       -> LEDR[1], HEX3:HEX2 count
//   debug             debug-mode level       -> LEDR[9] heartbeat
//   LEDR[9:0]         active-high LEDs (LEDR[8:2] tied low)
//   HEX0..HEX3        active-low 7-segment digits, bit order gfedcba
module indicadores_eventos #(
    parameter int STRETCH_CYCLES = 5000000,
    parameter int BLINK_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       abertura,
    input  logic       bandeira,
    input  logic       debug,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3
);

    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    // A 1-cycle blink period still needs a 1-bit counter.
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_CYCLES - 1);

    logic [SW-1:0] ab_stretch;
    logic [SW-1:0] bd_stretch;
    logic [7:0]    ab_bcd;      // {tens, units}
    logic [7:0]    bd_bcd;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    // Two-digit BCD increment that sticks at 99 instead of wrapping.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Pulse stretchers: reload on every event so retriggers extend the flash without a gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            ab_stretch <= '0;
            bd_stretch <= '0;
        end else begin
            if (abertura) begin
                ab_stretch <= STRETCH_LOAD;
            end else if (ab_stretch != '0) begin
                ab_stretch <= ab_stretch - SW'(1);
            end
            if (bandeira) begin
                bd_stretch <= STRETCH_LOAD;
            end else if (bd_stretch != '0) begin
                bd_stretch <= bd_stretch - SW'(1);
            end
        end
    end

    // Event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            ab_bcd <= 8'h00;
            bd_bcd <= 8'h00;
        end else begin
            if (abertura) begin
                ab_bcd <= bcd_inc(ab_bcd);
            end
            if (bandeira) begin
                bd_bcd <= bcd_inc(bd_bcd);
            end
        end
    end

    // Heartbeat: held cleared while debug is low so every debug-on starts with the same phase.
    always_ff @(posedge clk) begin
        if (reset || !debug) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // The phase register clears one cycle after debug falls; gating with debug
    // keeps the LED dark during that first debug-low cycle too.
    assign LEDR[0]   = (ab_stretch != '0);
    assign LEDR[1]   = (bd_stretch != '0);
    assign LEDR[8:2] = 7'b0;
    assign LEDR[9]   = blink_phase & debug;

    assign HEX0 = seg7(ab_bcd[3:0]);
    assign HEX1 = seg7(ab_bcd[7:4]);
    assign HEX2 = seg7(bd_bcd[3:0]);
    assign HEX3 = seg7(bd_bcd[7:4]);

endmodule

// File: tb/tb_indicadores_eventos.sv
module tb_indicadores_eventos;

    localparam int S = 4;
    localparam int B = 3;
    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};

    logic       clk = 1'b0;
    logic       reset, abertura, bandeira, debug;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    int compared   = 0;
    int mismatched = 0;

    indicadores_eventos #(.STRETCH_CYCLES(S), .BLINK_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .abertura(abertura), .bandeira(bandeira), .debug(debug),
        .LEDR(LEDR), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
    );

    always #5 clk = ~clk;

    // Behavioural model: cycle index of the last event per channel, event totals, and
    // the length of the current run of debug-high cycles.
    int cyc     = 0;
    int last_ab = -1000000;
    int last_bd = -1000000;
    int n_ab    = 0;
    int n_bd    = 0;
    int run     = 0;
    bit model_ok = 0;

    always @(posedge clk) begin
        if (reset) begin
            last_ab  = -1000000;
            last_bd  = -1000000;
            n_ab     = 0;
            n_bd     = 0;
            run      = 0;
            model_ok = 1;
        end else begin
            if (abertura) begin last_ab = cyc; n_ab++; end
            if (bandeira) begin last_bd = cyc; n_bd++; end
            if (debug) run++; else run = 0;
        end
        cyc++;
    end

    function automatic logic [9:0] exp_ledr();
        logic [9:0] e;
        e    = '0;
        e[0] = (cyc - last_ab >= 1) && (cyc - last_ab <= S);
        e[1] = (cyc - last_bd >= 1) && (cyc - last_bd <= S);
        e[9] = debug && (((run / B) % 2) == 1);
        return e;
    endfunction

    function automatic int sat(input int n);
        return (n > 99) ? 99 : n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_ok && !reset) begin
            chk("LEDR", 32'(LEDR), 32'(exp_ledr()));
            chk("HEX0", 32'(HEX0), 32'(SEG[sat(n_ab) % 10]));
            chk("HEX1", 32'(HEX1), 32'(SEG[sat(n_ab) / 10]));
            chk("HEX2", 32'(HEX2), 32'(SEG[sat(n_bd) % 10]));
            chk("HEX3", 32'(HEX3), 32'(SEG[sat(n_bd) / 10]));
        end
    end

    // Apply inputs for one cycle, then land 1 time unit after the closing edge.
    task automatic step(input logic a, input logic b, input logic d, input logic r);
        abertura = a;
        bandeira = b;
        debug    = d;
        reset    = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        abertura = 0; bandeira = 0; debug = 0; reset = 1;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        repeat (10) step(0, 0, 0, 0);
        chk("reset_ledr", 32'(LEDR), 32'h0);
        chk("reset_hex0", 32'(HEX0), 32'b1000000);
        chk("reset_hex3", 32'(HEX3), 32'b1000000);

        // Single pulse: lit for exactly S cycles.
        step(1, 0, 0, 0);
        chk("pulse_led_t1", 32'(LEDR[0]), 32'h1);
        chk("pulse_hex0", 32'(HEX0), 32'b1111001);
        chk("pulse_hex1", 32'(HEX1), 32'b1000000);
        chk("pulse_hex2", 32'(HEX2), 32'b1000000);
        repeat (3) step(0, 0, 0, 0);
        chk("pulse_led_t4", 32'(LEDR[0]), 32'h1);
        step(0, 0, 0, 0);
        chk("pulse_led_t5", 32'(LEDR[0]), 32'h0);

        // Retrigger at t and t+2: lit t+1..t+6.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        chk("retrig_led_t6", 32'(LEDR[0]), 32'h1);
        step(0, 0, 0, 0);
        chk("retrig_led_t7", 32'(LEDR[0]), 32'h0);
        chk("retrig_hex0", 32'(HEX0), 32'b0110000);

        // Both channels 12 times, then saturate bandeira.
        step(0, 0, 0, 1);
        repeat (12) step(1, 1, 0, 0);
        chk("both12_hex1", 32'(HEX1), 32'b1111001);
        chk("both12_hex0", 32'(HEX0), 32'b0100100);
        chk("both12_hex3", 32'(HEX3), 32'b1111001);
        chk("both12_hex2", 32'(HEX2), 32'b0100100);
        repeat (100) step(0, 1, 0, 0);
        chk("sat_hex3", 32'(HEX3), 32'b0010000);
        chk("sat_hex2", 32'(HEX2), 32'b0010000);
        chk("sat_hex0", 32'(HEX0), 32'b0100100);

        // Heartbeat from cycle t.
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("blink_t3", 32'(LEDR[9]), 32'h1);
        repeat (3) step(0, 0, 1, 0);
        chk("blink_t6", 32'(LEDR[9]), 32'h0);
        repeat (3) step(0, 0, 1, 0);
        chk("blink_t9", 32'(LEDR[9]), 32'h1);
        repeat (2) step(0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        chk("blink_restart", 32'(LEDR[9]), 32'h1);

        // Reset wins over a same-cycle event.
        step(0, 0, 1, 1);
        repeat (5) step(1, 0, 1, 0);
        chk("pre_reset_hex0", 32'(HEX0), 32'b0010010);
        step(1, 0, 1, 1);
        chk("rst_evt_hex0", 32'(HEX0), 32'b1000000);
        chk("rst_evt_led0", 32'(LEDR[0]), 32'h0);
        chk("rst_evt_led9", 32'(LEDR[9]), 32'h0);

        // Randomized traffic checked by the per-cycle compare process.
        begin
            logic d;
            d = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 19) == 0) d = ~d;
                step(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0), d,
                     ($urandom_range(0, 399) == 0));
            end
        end

        step(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
